// File: rtl/piece_driver_if.sv
// rtl/piece_driver_if.sv - placed-piece bus between piece_driver and gameboard
interface piece_driver_if;
  logic [19:0][9:0] occupied;
  logic [2:0]       piece_type;
  logic             drop_tick;
  logic             move_left;
  logic             move_right;
  logic [9:0]       square1x, square2x, square3x, square4x;
  logic [9:0]       square1y, square2y, square3y, square4y;
  logic             at_bottom;
  logic             game_over;

  modport master (
    input  occupied, piece_type, drop_tick, move_left, move_right,
    output square1x, square2x, square3x, square4x,
    output square1y, square2y, square3y, square4y,
    output at_bottom, game_over
  );

  modport slave (
    output occupied, piece_type, drop_tick, move_left, move_right,
    input  square1x, square2x, square3x, square4x,
    input  square1y, square2y, square3y, square4y,
    input  at_bottom, game_over
  );
endinterface

// File: rtl/piece_driver.sv
// rtl/piece_driver.sv - active tetromino driver: fall, shift, land strobe, respawn, game over
module piece_driver #(
  parameter int X_ORIGIN      = 200,
  parameter int Y_ORIGIN      = 0,
  parameter int CELL          = 20,
  parameter int SPAWN_COL     = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  piece_driver_if.master bus
);

  typedef enum logic [2:0] {SPAWN, FALL, LAND, SETTLE, OVER} state_t;

  typedef struct packed {
    logic [3:0][1:0] dc;
    logic [3:0]      dr;
  } offs_t;

  // Element i of dc/dr is square i+1's (col,row) offset from the anchor.
  function automatic offs_t shape_offs(input logic [2:0] t);
    offs_t o;
    case (t)
      3'd0:    begin o.dc = {2'd3, 2'd2, 2'd1, 2'd0}; o.dr = 4'b0000; end
      3'd2:    begin o.dc = {2'd1, 2'd2, 2'd1, 2'd0}; o.dr = 4'b1000; end
      3'd3:    begin o.dc = {2'd1, 2'd0, 2'd2, 2'd1}; o.dr = 4'b1100; end
      3'd4:    begin o.dc = {2'd2, 2'd1, 2'd1, 2'd0}; o.dr = 4'b1100; end
      3'd5:    begin o.dc = {2'd2, 2'd1, 2'd0, 2'd0}; o.dr = 4'b1110; end
      3'd6:    begin o.dc = {2'd2, 2'd1, 2'd0, 2'd2}; o.dr = 4'b1110; end
      default: begin o.dc = {2'd1, 2'd0, 2'd1, 2'd0}; o.dr = 4'b1100; end
    endcase
    return o;
  endfunction

  // Column/row math is done in int so col-1 from column 0 goes negative instead of wrapping.
  function automatic logic legal(input logic [2:0] t, input int col, input int row,
                                 input logic [19:0][9:0] occ);
    offs_t o;
    int    c, r;
    logic  ok;
    o  = shape_offs(t);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = col + int'(o.dc[i]);
      r = row + int'(o.dr[i]);
      if (c < 0 || c > 9 || r < 0 || r > 19) ok = 1'b0;
      else if (occ[r[4:0]][c[3:0]]) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [3:0][9:0] xs_of(input logic [2:0] t, input int col);
    offs_t           o;
    logic [3:0][9:0] res;
    o = shape_offs(t);
    for (int i = 0; i < 4; i++) res[i] = 10'(X_ORIGIN + CELL * (col + int'(o.dc[i])));
    return res;
  endfunction

  function automatic logic [3:0][9:0] ys_of(input logic [2:0] t, input int row);
    offs_t           o;
    logic [3:0][9:0] res;
    o = shape_offs(t);
    for (int i = 0; i < 4; i++) res[i] = 10'(Y_ORIGIN + CELL * (row + int'(o.dr[i])));
    return res;
  endfunction

  localparam logic [3:0][9:0] RST_X = xs_of(3'd0, SPAWN_COL);
  localparam logic [3:0][9:0] RST_Y = ys_of(3'd0, 0);

  state_t          state, state_n;
  logic [2:0]      shape, shape_n;
  logic [3:0]      col, col_n;
  logic [4:0]      row, row_n;
  logic [7:0]      cnt, cnt_n;
  logic [3:0][9:0] sq_x, sq_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SPAWN;
      shape <= 3'd0;
      col   <= 4'(SPAWN_COL);
      row   <= 5'd0;
      cnt   <= 8'd0;
      sq_x  <= RST_X;
      sq_y  <= RST_Y;
    end else begin
      state <= state_n;
      shape <= shape_n;
      col   <= col_n;
      row   <= row_n;
      cnt   <= cnt_n;
      sq_x  <= xs_of(shape, int'(col));
      sq_y  <= ys_of(shape, int'(row));
    end
  end

  always_comb begin
    state_n = state;
    shape_n = shape;
    col_n   = col;
    row_n   = row;
    cnt_n   = cnt;
    case (state)
      SPAWN: begin
        shape_n = bus.piece_type;
        col_n   = 4'(SPAWN_COL);
        row_n   = 5'd0;
        cnt_n   = 8'd0;
        state_n = legal(bus.piece_type, SPAWN_COL, 0, bus.occupied) ? FALL : OVER;
      end
      FALL: begin
        // A drop in the same cycle as a shift wins; the shift is discarded.
        if (bus.drop_tick) begin
          if (legal(shape, int'(col), int'(row) + 1, bus.occupied)) row_n = row + 5'd1;
          else state_n = LAND;
        end else if (bus.move_left && !bus.move_right) begin
          if (legal(shape, int'(col) - 1, int'(row), bus.occupied)) col_n = col - 4'd1;
        end else if (bus.move_right && !bus.move_left) begin
          if (legal(shape, int'(col) + 1, int'(row), bus.occupied)) col_n = col + 4'd1;
        end
      end
      LAND: begin
        state_n = SETTLE;
        cnt_n   = 8'd0;
      end
      SETTLE: begin
        if (cnt == 8'(SETTLE_CYCLES - 1)) state_n = SPAWN;
        else cnt_n = cnt + 8'd1;
      end
      default: state_n = OVER;
    endcase
  end

  assign bus.square1x  = sq_x[0];
  assign bus.square2x  = sq_x[1];
  assign bus.square3x  = sq_x[2];
  assign bus.square4x  = sq_x[3];
  assign bus.square1y  = sq_y[0];
  assign bus.square2y  = sq_y[1];
  assign bus.square3y  = sq_y[2];
  assign bus.square4y  = sq_y[3];
  assign bus.at_bottom = (state == LAND);
  assign bus.game_over = (state == OVER);

endmodule
